// File: rtl/branch_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC sequencer and its helpers.
// Contents:
//   PC_W_DEFAULT  - default PC / branch target width
//   state_e       - sequencer state encoding (FETCH=0, RESOLVE=1)
//   OFS_SIGN_BIT  - bit of the instruction constant holding the offset sign
//   OFS_MAG_W     - width of the offset magnitude field (const[5:0])
package branch_sequencer_pkg;

  localparam int PC_W_DEFAULT = 10;
  localparam int OFS_SIGN_BIT = 6;
  localparam int OFS_MAG_W    = 6;

  typedef enum logic {
    FETCH   = 1'b0,
    RESOLVE = 1'b1
  } state_e;

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch target calculator using the sign-magnitude offset rule.
// Ports:
//   br_pc    in  PC_W  PC of the branch instruction
//   br_const in  16    instruction constant; [6]=sign, [5:0]=magnitude,
//                      [15:7] carry no meaning for the offset
//   target   out PC_W  br_pc +/- magnitude, modulo 2^PC_W
// Shared with the hazard unit, so it holds no state.
module branch_target_adder
  import branch_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] br_pc,
  input  logic [15:0]     br_const,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] magnitude;
  logic            sign;
  logic            unused_const_bits;

  // Magnitude is zero-extended to PC width; wrap-around on add or subtract
  // is intended and falls out of the fixed-width arithmetic.
  assign magnitude         = PC_W'(br_const[OFS_MAG_W-1:0]);
  assign sign              = br_const[OFS_SIGN_BIT];
  assign unused_const_bits = ^br_const[15:OFS_SIGN_BIT+1];

  always_comb begin
    if (sign) begin
      target = br_pc - magnitude;
    end else begin
      target = br_pc + magnitude;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Owns the PC, accepts one branch at a time from decode, keeps fetching the
// not-taken path while the branch is outstanding and redirects/flushes when
// execute reports it taken.
// Ports:
//   clk        in  1      system clock, rising edge
//   reset      in  1      asynchronous active-high reset
//   stall      in  1      pipeline hazard stall, holds the PC
//   br_req     in  1      decode presents a branch (held until br_ack)
//   br_pc      in  PC_W   PC of the branch in decode
//   br_const   in  16     instruction constant (sign-magnitude offset)
//   res_valid  in  1      execute delivers a branch outcome
//   res_taken  in  1      branch outcome, qualified by res_valid
//   pc_out     out PC_W   current fetch PC
//   br_ack     out 1      branch accepted (combinational pulse)
//   busy       out 1      a branch is awaiting resolution
//   flush      out 1      kill wrong-path IF/ID instructions (one cycle)
//   taken_cnt  out CNT_W  saturating count of taken branches
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_req,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [15:0]      br_const,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic [PC_W-1:0]  pc_out,
  output logic             br_ack,
  output logic             busy,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  new_target;

  branch_target_adder #(
    .PC_W(PC_W)
  ) u_target_adder (
    .br_pc   (br_pc),
    .br_const(br_const),
    .target  (new_target)
  );

  // Next-state logic. Branch acceptance is only possible in FETCH with no
  // stall; in RESOLVE a taken outcome overrides stall and wins over any
  // pending request, which decode keeps holding until we return to FETCH.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    flush_d  = 1'b0;
    cnt_d    = cnt_q;
    br_ack   = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (!stall) begin
          pc_d = pc_q + PC_W'(1);
          if (br_req) begin
            // Reset gating keeps ack low while the async reset is held.
            br_ack   = !reset;
            target_d = new_target;
            state_d  = RESOLVE;
          end
        end
      end

      RESOLVE: begin
        if (res_valid && res_taken) begin
          pc_d    = target_q;
          flush_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = FETCH;
        end else begin
          // Predict-not-taken: keep fetching sequentially.
          if (!stall) begin
            pc_d = pc_q + PC_W'(1);
          end
          if (res_valid) begin
            state_d = FETCH;
          end
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers; reset abandons any outstanding branch without a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      target_q <= '0;
      flush_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      flush_q  <= flush_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pc_out    = pc_q;
  assign busy      = (state_q == RESOLVE);
  assign flush     = flush_q;
  assign taken_cnt = cnt_q;

endmodule
